weight_stream_sequencer: RTL and testbench

// Sequences a stored weight tensor out of a 1-cycle-latency on-chip weight memory onto the weights_V
// AXI-Stream consumed by a compute kernel. Emits WEIGHT_SDIM elements per beat and asserts tlast at

---
 rtl/weight_stream_sequencer.sv | 209 ++++++++++++++++++++
 tb/tb_weight_stream_sequencer.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/weight_stream_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : weight_stream_sequencer
// Purpose  : Streams a weight tensor from a 1-cycle-latency memory onto an
//            AXI-Stream through a 2-entry buffer. Optional stall counter is
//            enabled by defining WSEQ_STALL_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module weight_stream_sequencer #(
    parameter  int WEIGHT_BDIM = 64,
    parameter  int WEIGHT_SDIM = 8,
    parameter  int ELEM_W      = 4,
    parameter  int NUM_BLOCKS  = 4,
    parameter  int NUM_REPS    = 2,
    localparam int BEAT_W      = WEIGHT_SDIM * ELEM_W,
    localparam int BPB         = WEIGHT_BDIM / WEIGHT_SDIM,
    localparam int DEPTH       = NUM_BLOCKS * BPB,
    localparam int AW          = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              ap_clk,
    input  logic              ap_rst_n,
    input  logic              ap_start,
    output logic              ap_idle,
    output logic              ap_done,
    output logic              mem_rd_en,
    output logic [AW-1:0]     mem_addr,
    input  logic [BEAT_W-1:0] mem_rdata,
    output logic [BEAT_W-1:0] weights_V_tdata,
    output logic              weights_V_tvalid,
    input  logic              weights_V_tready,
    output logic              weights_V_tlast,
    output logic [31:0]       stall_cnt
);

    localparam int c_rw = (NUM_REPS > 1) ? $clog2(NUM_REPS) : 1;
    localparam int c_bw = (BPB > 1) ? $clog2(BPB) : 1;
    localparam logic [AW-1:0]   c_last_addr = AW'(DEPTH - 1);
    localparam logic [c_rw-1:0] c_last_rep  = c_rw'(NUM_REPS - 1);
    localparam logic [c_bw-1:0] c_last_bidx = c_bw'(BPB - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [AW-1:0]     r_addr;
    logic [c_rw-1:0]   r_rep;
    logic [c_bw-1:0]   r_bidx;
    logic              r_inflight;
    logic              r_inflight_last;
    logic [BEAT_W-1:0] r_data0;
    logic [BEAT_W-1:0] r_data1;
    logic              r_last0;
    logic              r_last1;
    logic [1:0]        r_count;
    logic              w_rd;
    logic              w_start;
    logic              w_space;
    logic              w_final_rd;
    logic              w_valid;
    logic              w_pop;
    logic              w_push;

    // Only issue a read when the buffer can absorb every outstanding response.
    assign w_space    = (r_count == 2'd0) || ((r_count == 2'd1) && !r_inflight);
    assign w_final_rd = (r_addr == c_last_addr) && (r_rep == c_last_rep);
    assign w_valid    = (r_count != 2'd0);
    assign w_pop      = w_valid && weights_V_tready;
    assign w_push     = r_inflight;

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_rd        = 1'b0;
        w_start     = 1'b0;
        ap_idle     = 1'b0;
        ap_done     = 1'b0;
        case (r_state)
            S_IDLE: begin
                ap_idle = 1'b1;
                if (ap_start) begin
                    w_start     = 1'b1;
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                w_rd = w_space;
                if (w_space && w_final_rd) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if ((r_count == 2'd0) && !r_inflight) begin
                    ap_done     = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_addr <= '0;
            r_rep  <= '0;
            r_bidx <= '0;
        end else if (w_start) begin
            r_addr <= '0;
            r_rep  <= '0;
            r_bidx <= '0;
        end else if (w_rd) begin
            if (r_addr == c_last_addr) begin
                r_addr <= '0;
                r_rep  <= (r_rep == c_last_rep) ? '0 : r_rep + 1'b1;
            end else begin
                r_addr <= r_addr + 1'b1;
            end
            r_bidx <= (r_bidx == c_last_bidx) ? '0 : r_bidx + 1'b1;
        end
    end

    // The tlast tag travels alongside the read so it lands with its data.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
        end else begin
            r_inflight      <= w_rd;
            r_inflight_last <= w_rd && (r_bidx == c_last_bidx);
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_data0 <= '0;
            r_data1 <= '0;
            r_last0 <= 1'b0;
            r_last1 <= 1'b0;
            r_count <= 2'd0;
        end else begin
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_count == 2'd0) begin
                        r_data0 <= mem_rdata;
                        r_last0 <= r_inflight_last;
                    end else begin
                        r_data1 <= mem_rdata;
                        r_last1 <= r_inflight_last;
                    end
                    r_count <= r_count + 2'd1;
                end
                2'b01: begin
                    r_data0 <= r_data1;
                    r_last0 <= r_last1;
                    r_count <= r_count - 2'd1;
                end
                2'b11: begin
                    if (r_count == 2'd1) begin
                        r_data0 <= mem_rdata;
                        r_last0 <= r_inflight_last;
                    end else begin
                        r_data0 <= r_data1;
                        r_last0 <= r_last1;
                        r_data1 <= mem_rdata;
                        r_last1 <= r_inflight_last;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign mem_rd_en        = w_rd;
    assign mem_addr         = r_addr;
    assign weights_V_tdata  = r_data0;
    assign weights_V_tvalid = w_valid;
    assign weights_V_tlast  = r_last0;

`ifdef WSEQ_STALL_CNT_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_stall_cnt <= '0;
        end else if (w_start) begin
            r_stall_cnt <= '0;
        end else if (w_valid && !weights_V_tready && (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`else
    assign stall_cnt = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_weight_stream_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_weight_stream_sequencer
// Purpose  : Directed/random bench for weight_stream_sequencer with a queue
//            model of the expected beat stream.
// Revision : 1.0 - initial release
// ============================================================================
module tb_weight_stream_sequencer;

    localparam int BDIM  = 64;
    localparam int SDIM  = 8;
    localparam int EW    = 4;
    localparam int NB    = 4;
    localparam int NR    = 2;
    localparam int BW    = SDIM * EW;
    localparam int BPB   = BDIM / SDIM;
    localparam int DEPTH = NB * BPB;
    localparam int AW    = $clog2(DEPTH);

    logic          ap_clk = 1'b0;
    logic          ap_rst_n = 1'b0;
    logic          ap_start = 1'b0;
    logic          ap_idle, ap_done, mem_rd_en;
    logic [AW-1:0] mem_addr;
    logic [BW-1:0] mem_rdata = '0;
    logic [BW-1:0] tdata;
    logic          tvalid, tlast;
    logic          tready = 1'b0;
    logic [31:0]   stall_cnt;

    logic          s_start = 1'b0;
    logic          s_idle, s_done, s_rd_en;
    logic [0:0]    s_addr;
    logic [BW-1:0] s_rdata = '0;
    logic [BW-1:0] s_tdata;
    logic          s_tvalid, s_tlast;
    logic          s_tready = 1'b0;
    logic [31:0]   s_stall;

    logic [BW-1:0] mem [DEPTH];
    logic [BW-1:0] s_mem;
    logic [BW-1:0] exp_d [$];
    logic          exp_l [$];
    int            vectors = 0;
    int            miscompares = 0;
    int            stall_exp = 0;

    always #5 ap_clk = ~ap_clk;

    weight_stream_sequencer #(
        .WEIGHT_BDIM(BDIM), .WEIGHT_SDIM(SDIM), .ELEM_W(EW),
        .NUM_BLOCKS(NB), .NUM_REPS(NR)
    ) dut (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ap_start(ap_start),
        .ap_idle(ap_idle), .ap_done(ap_done),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .weights_V_tdata(tdata), .weights_V_tvalid(tvalid),
        .weights_V_tready(tready), .weights_V_tlast(tlast),
        .stall_cnt(stall_cnt)
    );

    weight_stream_sequencer #(
        .WEIGHT_BDIM(SDIM), .WEIGHT_SDIM(SDIM), .ELEM_W(EW),
        .NUM_BLOCKS(1), .NUM_REPS(1)
    ) dut_small (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ap_start(s_start),
        .ap_idle(s_idle), .ap_done(s_done),
        .mem_rd_en(s_rd_en), .mem_addr(s_addr), .mem_rdata(s_rdata),
        .weights_V_tdata(s_tdata), .weights_V_tvalid(s_tvalid),
        .weights_V_tready(s_tready), .weights_V_tlast(s_tlast),
        .stall_cnt(s_stall)
    );

    // 1-cycle-latency memories
    always @(posedge ap_clk) begin
        if (mem_rd_en) mem_rdata <= mem[mem_addr];
        if (s_rd_en)   s_rdata   <= s_mem;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_idle"},   ap_idle,   1);
        chk({tag, "_done"},   ap_done,   0);
        chk({tag, "_rd_en"},  mem_rd_en, 0);
        chk({tag, "_addr"},   mem_addr,  0);
        chk({tag, "_tvalid"}, tvalid,    0);
        chk({tag, "_tlast"},  tlast,     0);
        chk({tag, "_tdata"},  tdata,     0);
        chk({tag, "_stall"},  stall_cnt, 0);
    endtask

    task automatic fill_mem(input bit ramp);
        for (int i = 0; i < DEPTH; i++) mem[i] = ramp ? BW'(i) : BW'($urandom);
    endtask

    // Expected stream: the whole tensor, replayed NR times, tlast per block end.
    task automatic build_exp();
        for (int r = 0; r < NR; r++)
            for (int a = 0; a < DEPTH; a++) begin
                exp_d.push_back(mem[a]);
                exp_l.push_back((a % BPB) == BPB - 1);
            end
    endtask

    task automatic start_pulse();
        @(negedge ap_clk);
        ap_start  = 1'b1;
        stall_exp = 0;
        @(negedge ap_clk);
        ap_start  = 1'b0;
    endtask

    // mode 0: always ready, 1: toggling, 2: random. stop_after>0 halts after that many beats.
    task automatic run_stream(input int mode, input int budget, input int stop_after,
                              output int first_v);
        int dones, beats;
        logic pv_stall, pl;
        logic [BW-1:0] pd, ed;
        logic el;
        dones = 0; beats = 0; pv_stall = 1'b0; pd = '0; pl = 1'b0; first_v = -1;
        for (int cyc = 0; cyc < budget; cyc++) begin
            @(negedge ap_clk);
            case (mode)
                0:       tready = 1'b1;
                1:       tready = (cyc % 2) == 0;
                default: tready = 1'($urandom_range(0, 1));
            endcase
            if (pv_stall) begin
                chk("axis_hold_valid", tvalid, 1);
                chk("axis_hold_data",  tdata,  pd);
                chk("axis_hold_last",  tlast,  pl);
            end
            if (tvalid && first_v < 0) first_v = cyc;
            if (tvalid && !tready) stall_exp++;
            pv_stall = tvalid && !tready;
            pd = tdata;
            pl = tlast;
            if (tvalid && tready) begin
                beats++;
                if (exp_d.size() == 0) begin
                    chk("extra_beat", 1, 0);
                end else begin
                    ed = exp_d.pop_front();
                    el = exp_l.pop_front();
                    chk("beat_data", tdata, ed);
                    chk("beat_last", tlast, el);
                end
            end
            if (ap_done) dones++;
            if (dones > 0 || (stop_after > 0 && beats == stop_after)) break;
        end
        if (stop_after == 0) begin
            chk("done_seen", dones, 1);
            chk("queue_empty", exp_d.size(), 0);
`ifdef WSEQ_STALL_CNT_EN
            chk("stall_cnt", stall_cnt, stall_exp);
`else
            chk("stall_cnt", stall_cnt, 0);
`endif
        end
    endtask

    initial begin
        int fv, rds, beats, dones;

        // Reset state
        #1;
        chk_reset_outputs("reset");
        chk("small_idle", s_idle, 1);
        @(negedge ap_clk);
        ap_rst_n = 1'b1;

        // Ramp memory, always ready: latency, order, tlast, single done
        fill_mem(1'b1);
        build_exp();
        tready = 1'b1;
        start_pulse();
        chk("run_idle", ap_idle, 0);
        chk("first_rd_en", mem_rd_en, 1);
        chk("first_addr", mem_addr, 0);
        chk("lat_c1_tvalid", tvalid, 0);
        @(negedge ap_clk);
        chk("lat_c2_tvalid", tvalid, 0);
        run_stream(0, 200, 0, fv);
        chk("lat_first_valid", fv, 0);
        @(negedge ap_clk);
        chk("done_pulse_width", ap_done, 0);
        chk("back_to_idle", ap_idle, 1);

        // Toggling ready, random contents
        fill_mem(1'b0);
        build_exp();
        start_pulse();
        run_stream(1, 400, 0, fv);

        // Random ready, random contents
        fill_mem(1'b0);
        build_exp();
        start_pulse();
        run_stream(2, 600, 0, fv);

        // Ready held low: first beat holds, only two reads issued
        fill_mem(1'b1);
        build_exp();
        tready = 1'b0;
        start_pulse();
        rds = 0;
        for (int i = 0; i < 25; i++) begin
            if (i > 0) @(negedge ap_clk);
            if (mem_rd_en) rds++;
            if (tvalid) begin
                stall_exp++;
                chk("stalled_tdata", tdata, 0);
            end
        end
        chk("stalled_reads", rds, 2);
        run_stream(0, 200, 0, fv);

        // Reset mid-stream, then a fresh run restarts at address 0
        fill_mem(1'b1);
        build_exp();
        start_pulse();
        run_stream(0, 200, 10, fv);
        #1 ap_rst_n = 1'b0;
        #1;
        chk_reset_outputs("midrun_reset");
        @(negedge ap_clk);
        chk("no_done_after_reset", ap_done, 0);
        ap_rst_n = 1'b1;
        exp_d.delete();
        exp_l.delete();
        build_exp();
        start_pulse();
        run_stream(0, 200, 0, fv);

        // ap_start held: back-to-back runs with a single idle cycle between
        fill_mem(1'b0);
        build_exp();
        @(negedge ap_clk);
        ap_start  = 1'b1;
        stall_exp = 0;
        run_stream(0, 200, 0, fv);
        build_exp();
        @(negedge ap_clk);
        chk("held_idle_1", ap_idle, 1);
        stall_exp = 0;
        @(negedge ap_clk);
        chk("held_idle_2", ap_idle, 0);
        run_stream(2, 600, 0, fv);
        ap_start = 1'b0;
        @(negedge ap_clk);
        chk("held_end_idle_1", ap_idle, 1);
        @(negedge ap_clk);
        chk("held_end_idle_2", ap_idle, 1);

        // Degenerate geometry: one beat per tensor
        s_mem = BW'($urandom);
        s_tready = 1'b1;
        @(negedge ap_clk);
        s_start = 1'b1;
        @(negedge ap_clk);
        s_start = 1'b0;
        beats = 0;
        dones = 0;
        for (int i = 0; i < 20; i++) begin
            if (s_tvalid) begin
                beats++;
                chk("small_tdata", s_tdata, s_mem);
                chk("small_tlast", s_tlast, 1);
            end
            if (s_done) begin
                dones++;
                break;
            end
            @(negedge ap_clk);
        end
        chk("small_beats", beats, 1);
        chk("small_done", dones, 1);
        @(negedge ap_clk);
        chk("small_idle_after", s_idle, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
